intr_ctrl: RTL
==============

# intr_ctrl

Parametrised vectored interrupt controller that replaces the CPU's single `interrupt` line with `NUM_IRQ` prioritised, maskable sources and supports nested service up to `NEST_DEPTH` levels. It sits between the external interrupt pins and the decode-stage hazard logic. It raises a request toward the pipeline, provides the vector address the fetch stage loads the ISR pointer from, and tracks the stack of in-service interrupt IDs across return-from-interrupt.

## Interface
- `NUM_IRQ`, default 4: number of interrupt sources, 2..16.
- `NEST_DEPTH`, default 2: maximum simultaneously in-service interrupts, 1..8.
- `ADDR_W`, default 8: instruction/data address width.
- `VEC_BASE`, default 1: memory address of the ISR pointer for ID 0.
- `MASK_RST`, default all ones: enable-mask value at reset.
- `IDW`, derived: max(1, clog2(NUM_IRQ)).

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `irq`  in  NUM_IRQ  interrupt lines, rising-edge triggered.
- `mask_we`  in  1  load enable mask.
- `mask_data`  in  NUM_IRQ  new mask (1 = enabled).
- `pipe_ready`  in  1  pipeline can accept an interrupt this cycle (no stall, no branch pending).
- `intr_ack`  in  1  pipeline accepted the request (1-cycle pulse).
- `rti`  in  1  return-from-interrupt retired (1-cycle pulse).
- `intr_req`  out  1  request to the pipeline.
- `intr_id`  out  IDW  ID of the requested interrupt.
- `vec_addr`  out  ADDR_W  VEC_BASE + intr_id, modulo 2^ADDR_W.
- `intr_active`  out  1  depth != 0.
- `depth`  out  clog2(NEST_DEPTH+1)  current nesting depth.
- `pending`  out  NUM_IRQ  latched pending bits.
- `mask`  out  NUM_IRQ  current enable mask.

## Operation
- Edge detect: `irq_q` registers `irq`. A rising edge (irq & ~irq_q) sets `pending[i]`.
- Priority: lower index = higher priority. Current level = ID on top of service stack; with the stack empty, every ID is above level.
- Eligible = pending & mask & {IDs strictly higher priority than current level}. No eligible IDs while depth == NEST_DEPTH (stack full).
- FSM IDLE:
  - Go to REQ when any ID is eligible and `pipe_ready` = 1.
  - On that transition, latch `intr_id` = highest-priority eligible ID and set `vec_addr` accordingly.
- FSM REQ:
  - `intr_req` = 1. `intr_id` and `vec_addr` are frozen; there is no re-arbitration, and mask or pending changes do not withdraw the request.
  - On `intr_ack`: push `intr_id`, depth+1, clear `pending[intr_id]`, go to IDLE.
- `intr_ack` outside REQ is ignored.
- `rti` with depth > 0: pop, depth−1. `rti` with depth 0 is ignored.
- Same-cycle `rti` and `intr_ack`: pop, then push. Net depth is unchanged and the new ID becomes the top.
- Same-cycle clear (ack) and new edge on the same line: the set wins, so pending stays 1.
- `mask_we`: mask ← `mask_data` at the next edge. Pending bits are unaffected by the mask; masked edges are still latched.
- Reset values:
  - state IDLE, `intr_req` 0, `intr_id` 0, `vec_addr` VEC_BASE.
  - `pending` 0, `mask` MASK_RST, depth 0, `intr_active` 0, stack contents 0.
  - `irq_q` 0, so a line high at reset release registers an edge on the first post-reset cycle.
- Reset mid-request or mid-service drops everything immediately, with no ack or rti required.

## Timing
- Edge k samples a new `irq` high. `pending` is visible after edge k.
- Arbitration uses registered `pending`/`mask`. `intr_req` rises after edge k+1 if `pipe_ready` was high at k+1, so irq→req latency is 2 cycles.
- `pipe_ready` low delays entry to REQ cycle-for-cycle. Once in REQ, `pipe_ready` is ignored.
- After the edge sampling `intr_ack`:
  - `intr_req` drops, `depth`/`intr_active` update, pending clears.
  - The earliest next `intr_req` (higher-priority ID) is one cycle later.
- `rti` updates depth/level after its edge. A lower-priority pending ID may request on the following cycle.

## Test plan
- NUM_IRQ=4, VEC_BASE=1: pulse `irq[2]`, `pipe_ready`=1 → `intr_req` high 2 cycles later, `intr_id`=2, `vec_addr`=3. Ack → `depth`=1, `pending[2]`=0.
- Assert `irq[3]` and `irq[1]` on the same edge → ID 1 served first. After ack plus `rti`, ID 3 requests with `vec_addr`=4.
- Nesting, NEST_DEPTH=2:
  - In service of ID 2: `irq[0]` preempts (depth 2).
  - `irq[1]` then stays pending with no request (stack full), and is also blocked while ID 0 is on top.
  - After two `rti`: ID 1 requests.
- `mask`=4'b1011, pulse `irq[2]` → `pending[2]`=1, no request. Write mask 4'b1111 → request with ID 2 two cycles later.
- `pipe_ready` held low 5 cycles with `pending[0]` set → no request. Request asserts the cycle after `pipe_ready` rises.
- Reset asserted while in REQ with depth=1 → next cycle all outputs at reset values. `irq[0]` held high through reset → request for ID 0 two cycles after release.

Source files
------------

// File: rtl/intr_ctrl.sv
// intr_ctrl: vectored interrupt controller with prioritised, maskable, edge-triggered sources and nested service
module intr_ctrl #(
  parameter int NUM_IRQ = 4,
  parameter int NEST_DEPTH = 2,
  parameter int ADDR_W = 8,
  parameter int VEC_BASE = 1,
  parameter logic [NUM_IRQ-1:0] MASK_RST = '1,
  localparam int IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
  localparam int DW = $clog2(NEST_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_data,
  input  logic               pipe_ready,
  input  logic               intr_ack,
  input  logic               rti,
  output logic               intr_req,
  output logic [IDW-1:0]     intr_id,
  output logic [ADDR_W-1:0]  vec_addr,
  output logic               intr_active,
  output logic [DW-1:0]      depth,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t r_state, w_next;
  logic [NUM_IRQ-1:0] r_irq_q, r_pend, r_mask, w_elig, w_clr;
  logic [IDW-1:0] r_id, w_top, w_best;
  logic [DW-1:0] r_depth, w_slot;
  logic [IDW-1:0] r_stack [NEST_DEPTH];
  logic w_any, w_push, w_pop;
  always_comb begin
    w_top = '0;
    for (int j = 0; j < NEST_DEPTH; j++) w_top = (DW'(j + 1) == r_depth) ? r_stack[j] : w_top;
  end
  always_comb begin
    w_elig = '0;
    w_best = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      w_elig[i] = r_pend[i] & r_mask[i] & (r_depth == '0 || IDW'(i) < w_top) & (r_depth != DW'(NEST_DEPTH));
      w_best = w_elig[i] ? IDW'(i) : w_best;
    end
  end
  assign w_any  = |w_elig;
  assign w_push = (r_state == REQ) && intr_ack;
  assign w_pop  = rti && (r_depth != '0);
  assign w_slot = r_depth - DW'(w_pop);
  assign w_clr  = w_push ? (NUM_IRQ'(1) << r_id) : '0;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? ((w_any && pipe_ready) ? REQ : IDLE) : (intr_ack ? IDLE : REQ);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_irq_q <= '0;
      r_pend  <= '0;
      r_mask  <= MASK_RST;
      r_id    <= '0;
      r_depth <= '0;
      for (int j = 0; j < NEST_DEPTH; j++) r_stack[j] <= '0;
    end else begin
      r_state <= w_next;
      r_irq_q <= irq;
      r_pend  <= (r_pend & ~w_clr) | (irq & ~r_irq_q);
      if (mask_we) r_mask <= mask_data;
      if (r_state == IDLE && w_next == REQ) r_id <= w_best;
      r_depth <= r_depth + DW'(w_push) - DW'(w_pop);
      for (int j = 0; j < NEST_DEPTH; j++)
        if (w_push && DW'(j) == w_slot) r_stack[j] <= r_id;
    end
  end
  assign intr_req    = (r_state == REQ);
  assign intr_id     = r_id;
  assign vec_addr    = ADDR_W'(VEC_BASE) + ADDR_W'(r_id);
  assign intr_active = (r_depth != '0);
  assign depth       = r_depth;
  assign pending     = r_pend;
  assign mask        = r_mask;
endmodule
